// File: rtl/memory_stage.sv
// rvga memory stage: issues loads/stores to the data-memory port, stalls upstream while an
// access is outstanding, and registers the memory control word for writeback.
package rvga_pkg;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
    } rvga_execute_cword;

    typedef struct packed {
        rvga_execute_cword ex;
        logic [31:0]       rd_data;
        logic              misalign_v;
    } rvga_memory_cword;
endpackage

module memory_stage
    import rvga_pkg::*;
#(
    parameter int addr_width_p = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 stall_v_i,
    input  logic                                 flush_v_i,
    input  logic [$bits(rvga_execute_cword)-1:0] cword_i,
    output logic                                 stall_v_o,
    output logic [$bits(rvga_memory_cword)-1:0]  cword_o,
    output logic                                 dmem_req_v_o,
    input  logic                                 dmem_req_ready_i,
    output logic                                 dmem_we_o,
    output logic [addr_width_p-1:0]              dmem_addr_o,
    output logic [31:0]                          dmem_wdata_o,
    output logic [3:0]                           dmem_wmask_o,
    input  logic                                 dmem_resp_v_i,
    input  logic [31:0]                          dmem_rdata_i
);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;

    state_e            state_r;
    logic              buf_v_r;
    logic [31:0]       buf_data_r;

    rvga_execute_cword ex;
    rvga_memory_cword  mem_cw;
    logic              is_load, is_store, is_memop, misalign, mem_go;
    logic              issue, accept, store_done, resp_ready, complete;
    logic [1:0]        off, size;
    logic [31:0]       resp_word, shifted, load_data;

    assign ex       = cword_i;
    assign off      = ex.alu_result[1:0];
    assign size     = ex.funct3[1:0];
    assign is_load  = (ex.opcode == OPC_LOAD);
    assign is_store = (ex.opcode == OPC_STORE);
    assign is_memop = is_load | is_store;
    assign misalign = is_memop & (((size == 2'b01) & off[0]) | ((size == 2'b10) & (off != 2'b00)));
    assign mem_go   = is_memop & ~misalign;

    // NOTE: reset gates the combinational request and stall so both drop without a clock edge.
    assign issue        = rst_i & (state_r == IDLE) & mem_go & ~stall_v_i & ~flush_v_i;
    assign accept       = issue & dmem_req_ready_i;
    assign store_done   = accept & is_store;
    assign dmem_req_v_o = issue;
    assign stall_v_o    = rst_i & ((state_r != IDLE) | (mem_go & ~flush_v_i & ~store_done));

    assign dmem_we_o   = is_store;
    assign dmem_addr_o = {ex.alu_result[addr_width_p-1:2], 2'b00};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        dmem_wdata_o = ex.rs2_data;
        dmem_wmask_o = 4'h0;
        unique case (size)
            2'b00: begin
                dmem_wdata_o = {4{ex.rs2_data[7:0]}};
                dmem_wmask_o = 4'b0001 << off;
            end
            2'b01: begin
                dmem_wdata_o = {2{ex.rs2_data[15:0]}};
                dmem_wmask_o = 4'b0011 << off;
            end
            default: begin
                dmem_wdata_o = ex.rs2_data;
                dmem_wmask_o = 4'hF;
            end
        endcase
        if (!is_store) dmem_wmask_o = 4'h0;
    end

    // A response captured while stalled takes priority over the live bus.
    assign resp_word = buf_v_r ? buf_data_r : dmem_rdata_i;
    assign shifted   = resp_word >> {off, 3'b000};

    always_comb begin
        load_data = resp_word;
        unique case (ex.funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = resp_word;
        endcase
    end

    always_comb begin
        mem_cw.ex         = ex;
        mem_cw.misalign_v = misalign;
        mem_cw.rd_data    = misalign ? 32'h0 : (is_load ? load_data : ex.alu_result);
    end

    assign resp_ready = dmem_resp_v_i | buf_v_r;
    assign complete   = ~flush_v_i & (((state_r == IDLE) & (~mem_go | store_done)) |
                                      ((state_r == WAIT) & resp_ready));

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= IDLE;
            buf_v_r    <= 1'b0;
            buf_data_r <= 32'h0;
            cword_o    <= '0;
        end else begin
            if (!stall_v_i) cword_o <= complete ? mem_cw : '0;
            unique case (state_r)
                IDLE: if (accept && is_load) state_r <= WAIT;
                WAIT: begin
                    if (flush_v_i) begin
                        state_r <= resp_ready ? IDLE : DRAIN;
                        buf_v_r <= 1'b0;
                    end else if (!stall_v_i && resp_ready) begin
                        state_r <= IDLE;
                        buf_v_r <= 1'b0;
                    end else if (stall_v_i && dmem_resp_v_i) begin
                        buf_v_r    <= 1'b1;
                        buf_data_r <= dmem_rdata_i;
                    end
                end
                DRAIN: if (dmem_resp_v_i) state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage against a byte-level reference model.
module tb_memory_stage;
    import rvga_pkg::*;

    localparam int AW = 32;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0010011;

    logic                                 clk_i = 1'b0;
    logic                                 rst_i;
    logic                                 stall_v_i, flush_v_i;
    logic [$bits(rvga_execute_cword)-1:0] cword_i;
    logic                                 stall_v_o;
    logic [$bits(rvga_memory_cword)-1:0]  cword_o;
    logic                                 dmem_req_v_o, dmem_req_ready_i, dmem_we_o;
    logic [AW-1:0]                        dmem_addr_o;
    logic [31:0]                          dmem_wdata_o;
    logic [3:0]                           dmem_wmask_o;
    logic                                 dmem_resp_v_i;
    logic [31:0]                          dmem_rdata_i;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    memory_stage #(.addr_width_p(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_v_i(stall_v_i), .flush_v_i(flush_v_i),
        .cword_i(cword_i), .stall_v_o(stall_v_o), .cword_o(cword_o),
        .dmem_req_v_o(dmem_req_v_o), .dmem_req_ready_i(dmem_req_ready_i), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
        .dmem_resp_v_i(dmem_resp_v_i), .dmem_rdata_i(dmem_rdata_i)
    );

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] s, b, h;
        s = word >> (8 * (addr % 4));
        b = s % 256;
        h = s % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] m;
        int base;
        m    = 4'h0;
        base = int'(addr % 4);
        for (int i = 0; i < nbytes(f3); i++) m[base + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] w;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic rvga_memory_cword model_cword(input rvga_execute_cword c, input logic [31:0] word);
        rvga_memory_cword m;
        logic memop, mis;
        memop = (c.opcode == OP_LOAD) || (c.opcode == OP_STORE);
        mis   = memop && ((c.alu_result % nbytes(c.funct3)) != 0);
        m.ex = c;
        m.misalign_v = mis;
        if (mis)                       m.rd_data = 32'h0;
        else if (c.opcode == OP_LOAD)  m.rd_data = model_load(c.funct3, c.alu_result, word);
        else                           m.rd_data = c.alu_result;
        return m;
    endfunction

    function automatic rvga_execute_cword make_cw(input logic [6:0] opc, input logic [2:0] f3,
                                                  input logic [31:0] alu);
        rvga_execute_cword c;
        c.pc         = $urandom;
        c.opcode     = opc;
        c.rd         = 5'($urandom);
        c.funct3     = f3;
        c.alu_result = alu;
        c.rs2_data   = $urandom;
        return c;
    endfunction

    function automatic logic [31:0] aligned_addr(input logic [2:0] f3);
        logic [31:0] a;
        a = $urandom;
        return a - (a % nbytes(f3));
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- transaction drivers with inline checks ----------------
    task automatic run_load(input rvga_execute_cword cw, input int not_ready, input int gap,
                            input logic [31:0] word, input string tag);
        rvga_memory_cword exp;
        logic [31:0] exp_addr;
        int accepts;
        exp      = model_cword(cw, word);
        exp_addr = cw.alu_result - (cw.alu_result % 4);
        accepts  = 0;
        cword_i  = cw;
        for (int i = 0; i <= not_ready; i++) begin
            dmem_req_ready_i = (i == not_ready);
            #1;
            total++;
            if ({dmem_req_v_o, dmem_we_o, dmem_addr_o, dmem_wmask_o} !== {1'b1, 1'b0, exp_addr, 4'h0}) begin
                bad++;
                $display("FAIL %s req: got v=%b we=%b addr=%h mask=%b, want v=1 we=0 addr=%h mask=0000",
                         tag, dmem_req_v_o, dmem_we_o, dmem_addr_o, dmem_wmask_o, exp_addr);
            end
            total++;
            if (stall_v_o !== 1'b1) begin
                bad++; $display("FAIL %s issue_stall: got %b want 1", tag, stall_v_o);
            end
            if (dmem_req_v_o && dmem_req_ready_i) accepts++;
            tick();
            total++;
            if (cword_o !== '0) begin
                bad++; $display("FAIL %s bubble: got %h want 0", tag, cword_o);
            end
        end
        dmem_req_ready_i = 1'b0;
        for (int i = 1; i < gap; i++) begin
            #1;
            total++;
            if ({stall_v_o, dmem_req_v_o} !== 2'b10) begin
                bad++; $display("FAIL %s wait: got stall=%b req=%b want 1/0", tag, stall_v_o, dmem_req_v_o);
            end
            tick();
        end
        dmem_resp_v_i = 1'b1;
        dmem_rdata_i  = word;
        #1;
        total++;
        if ({stall_v_o, dmem_req_v_o} !== 2'b10) begin
            bad++; $display("FAIL %s resp_cycle: got stall=%b req=%b want 1/0", tag, stall_v_o, dmem_req_v_o);
        end
        tick();
        dmem_resp_v_i = 1'b0;
        dmem_rdata_i  = $urandom;
        total++;
        if (cword_o !== exp) begin
            bad++; $display("FAIL %s cword: got %h want %h", tag, cword_o, exp);
        end
        total++;
        if (accepts != 1) begin
            bad++; $display("FAIL %s accepts: got %0d want 1", tag, accepts);
        end
        cword_i = make_cw(OP_ALU, 3'd0, $urandom);
        #1;
        total++;
        if (stall_v_o !== 1'b0) begin
            bad++; $display("FAIL %s after_stall: got %b want 0", tag, stall_v_o);
        end
    endtask

    task automatic run_store(input rvga_execute_cword cw, input string tag);
        logic [31:0] exp_addr;
        exp_addr = cw.alu_result - (cw.alu_result % 4);
        cword_i = cw;
        dmem_req_ready_i = 1'b1;
        #1;
        total++;
        if ({dmem_req_v_o, dmem_we_o, stall_v_o, dmem_addr_o, dmem_wmask_o, dmem_wdata_o} !==
            {1'b1, 1'b1, 1'b0, exp_addr, model_mask(cw.funct3, cw.alu_result), model_wdata(cw.funct3, cw.rs2_data)}) begin
            bad++;
            $display("FAIL %s req: got v=%b we=%b stall=%b addr=%h mask=%b wdata=%h, want 1/1/0 %h %b %h",
                     tag, dmem_req_v_o, dmem_we_o, stall_v_o, dmem_addr_o, dmem_wmask_o, dmem_wdata_o,
                     exp_addr, model_mask(cw.funct3, cw.alu_result), model_wdata(cw.funct3, cw.rs2_data));
        end
        tick();
        dmem_req_ready_i = 1'b0;
        total++;
        if (cword_o !== model_cword(cw, 32'h0)) begin
            bad++; $display("FAIL %s cword: got %h want %h", tag, cword_o, model_cword(cw, 32'h0));
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b0; stall_v_i = 1'b0; flush_v_i = 1'b0;
        dmem_req_ready_i = 1'b1; dmem_resp_v_i = 1'b0; dmem_rdata_i = 32'h0;
        cword_i = make_cw(OP_LOAD, 3'd2, 32'h0000_0100);
        #3;
        total++;
        if ({cword_o, dmem_req_v_o, stall_v_o} !== '0) begin
            bad++; $display("FAIL reset: got cword=%h req=%b stall=%b want all 0", cword_o, dmem_req_v_o, stall_v_o);
        end
        tick();
        cword_i = make_cw(OP_ALU, 3'd0, 32'h0);
        dmem_req_ready_i = 1'b0;
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        logic [6:0] ops [4];
        rvga_execute_cword a, b;
        ops[0] = OP_ALU; ops[1] = 7'b0110011; ops[2] = 7'b0110111; ops[3] = 7'b1101111;
        for (int i = 0; i < 8; i++) begin
            a = make_cw(ops[$urandom_range(0, 3)], 3'($urandom), $urandom);
            cword_i = a;
            #1;
            total++;
            if ({dmem_req_v_o, stall_v_o} !== 2'b00) begin
                bad++; $display("FAIL pass_req: got req=%b stall=%b want 0/0", dmem_req_v_o, stall_v_o);
            end
            tick();
            total++;
            if (cword_o !== model_cword(a, 32'h0)) begin
                bad++; $display("FAIL pass_cword: got %h want %h", cword_o, model_cword(a, 32'h0));
            end
        end
        b = make_cw(OP_ALU, 3'd0, $urandom);
        stall_v_i = 1'b1;
        cword_i = b;
        tick();
        total++;
        if (cword_o !== model_cword(a, 32'h0)) begin
            bad++; $display("FAIL pass_hold: got %h want %h", cword_o, model_cword(a, 32'h0));
        end
        stall_v_i = 1'b0;
        tick();
        total++;
        if (cword_o !== model_cword(b, 32'h0)) begin
            bad++; $display("FAIL pass_release: got %h want %h", cword_o, model_cword(b, 32'h0));
        end
    endtask

    task automatic test_store();
        rvga_execute_cword cw;
        logic [2:0] f3;
        cw = make_cw(OP_STORE, 3'd0, 32'h0000_1003);
        cw.rs2_data = 32'hAABB_CCDD;
        cword_i = cw;
        dmem_req_ready_i = 1'b1;
        #1;
        total++;
        if ({dmem_addr_o, dmem_wmask_o, dmem_wdata_o, dmem_we_o, dmem_req_v_o, stall_v_o} !==
            {32'h0000_1000, 4'b1000, 32'hDDDD_DDDD, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL sb_direct: got addr=%h mask=%b wdata=%h we=%b req=%b stall=%b, want 00001000 1000 dddddddd 1 1 0",
                     dmem_addr_o, dmem_wmask_o, dmem_wdata_o, dmem_we_o, dmem_req_v_o, stall_v_o);
        end
        tick();
        dmem_req_ready_i = 1'b0;
        total++;
        if (cword_o !== model_cword(cw, 32'h0)) begin
            bad++; $display("FAIL sb_cword: got %h want %h", cword_o, model_cword(cw, 32'h0));
        end
        for (int i = 0; i < 9; i++) begin
            f3 = 3'(i % 3);
            run_store(make_cw(OP_STORE, f3, aligned_addr(f3)), "store_rand");
        end
    endtask

    task automatic test_load_signed();
        run_load(make_cw(OP_LOAD, 3'd1, 32'h0000_2002), 0, 1, 32'h8001_1234, "lh_signed");
    endtask

    task automatic test_backpressure();
        run_load(make_cw(OP_LOAD, 3'd2, 32'h0000_3000), 3, 1, 32'h8081_82F3, "lw_backpressure");
        run_load(make_cw(OP_LOAD, 3'd4, 32'h0000_3000), 0, 2, 32'h8081_82F3, "lbu_zext");
    endtask

    task automatic test_random_loads();
        logic [2:0] f3s [5];
        logic [2:0] f3;
        f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2; f3s[3] = 3'd4; f3s[4] = 3'd5;
        for (int i = 0; i < 20; i++) begin
            f3 = f3s[$urandom_range(0, 4)];
            run_load(make_cw(OP_LOAD, f3, aligned_addr(f3)), $urandom_range(0, 2),
                     $urandom_range(1, 3), $urandom, "load_rand");
        end
    endtask

    task automatic test_flush_wait();
        rvga_execute_cword nxt;
        cword_i = make_cw(OP_LOAD, 3'd2, aligned_addr(3'd2));
        dmem_req_ready_i = 1'b1;
        tick();
        dmem_req_ready_i = 1'b0;
        flush_v_i = 1'b1;
        #1;
        total++;
        if ({stall_v_o, dmem_req_v_o} !== 2'b10) begin
            bad++; $display("FAIL flush_cycle: got stall=%b req=%b want 1/0", stall_v_o, dmem_req_v_o);
        end
        tick();
        flush_v_i = 1'b0;
        nxt = make_cw(OP_STORE, 3'd2, aligned_addr(3'd2));
        cword_i = nxt;
        dmem_req_ready_i = 1'b1;
        #1;
        total++;
        if ({stall_v_o, dmem_req_v_o, cword_o != '0} !== 3'b100) begin
            bad++; $display("FAIL drain_hold: got stall=%b req=%b cword=%h want 1/0/0", stall_v_o, dmem_req_v_o, cword_o);
        end
        tick();
        dmem_resp_v_i = 1'b1;
        dmem_rdata_i  = $urandom;
        #1;
        total++;
        if ({stall_v_o, dmem_req_v_o} !== 2'b10) begin
            bad++; $display("FAIL drain_resp: got stall=%b req=%b want 1/0", stall_v_o, dmem_req_v_o);
        end
        tick();
        dmem_resp_v_i = 1'b0;
        total++;
        if (cword_o !== '0) begin
            bad++; $display("FAIL drain_discard: got %h want 0", cword_o);
        end
        run_store(nxt, "after_drain");
        // Flush coinciding with the response returns straight to IDLE.
        cword_i = make_cw(OP_LOAD, 3'd0, $urandom);
        dmem_req_ready_i = 1'b1;
        tick();
        dmem_req_ready_i = 1'b0;
        flush_v_i = 1'b1;
        dmem_resp_v_i = 1'b1;
        tick();
        flush_v_i = 1'b0;
        dmem_resp_v_i = 1'b0;
        cword_i = make_cw(OP_ALU, 3'd0, $urandom);
        #1;
        total++;
        if ({stall_v_o, cword_o != '0} !== 2'b00) begin
            bad++; $display("FAIL flush_resp: got stall=%b cword=%h want 0/0", stall_v_o, cword_o);
        end
        tick();
    endtask

    task automatic test_misalign();
        rvga_execute_cword cw;
        logic [31:0] a;
        logic [2:0] f3;
        logic [6:0] opc;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                cw = make_cw(OP_LOAD, 3'd2, 32'h0000_0006);
            end else begin
                opc = ($urandom_range(0, 1) == 1) ? OP_STORE : OP_LOAD;
                case ($urandom_range(0, 2))
                    0:       f3 = 3'd1;
                    1:       f3 = 3'd2;
                    default: f3 = (opc == OP_LOAD) ? 3'd5 : 3'd1;
                endcase
                a = $urandom;
                a = a - (a % 4) + ((nbytes(f3) == 2) ? 32'(2 * $urandom_range(0, 1) + 1) : 32'($urandom_range(1, 3)));
                cw = make_cw(opc, f3, a);
            end
            cword_i = cw;
            dmem_req_ready_i = 1'b1;
            #1;
            total++;
            if ({dmem_req_v_o, stall_v_o} !== 2'b00) begin
                bad++; $display("FAIL misalign_req: got req=%b stall=%b want 0/0", dmem_req_v_o, stall_v_o);
            end
            tick();
            total++;
            if (cword_o !== model_cword(cw, 32'h0)) begin
                bad++; $display("FAIL misalign_cword: got %h want %h", cword_o, model_cword(cw, 32'h0));
            end
        end
        dmem_req_ready_i = 1'b0;
    endtask

    task automatic test_stall_buffer();
        rvga_execute_cword cw;
        logic [31:0] word;
        cw   = make_cw(OP_LOAD, 3'd0, aligned_addr(3'd0));
        word = $urandom | 32'h8080_8080;
        cword_i = cw;
        dmem_req_ready_i = 1'b1;
        tick();
        dmem_req_ready_i = 1'b0;
        stall_v_i = 1'b1;
        dmem_resp_v_i = 1'b1;
        dmem_rdata_i  = word;
        tick();
        dmem_resp_v_i = 1'b0;
        dmem_rdata_i  = ~word;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if ({stall_v_o, dmem_req_v_o, cword_o != '0} !== 3'b100) begin
                bad++; $display("FAIL stall_hold: got stall=%b req=%b cword=%h want 1/0/0", stall_v_o, dmem_req_v_o, cword_o);
            end
            tick();
        end
        stall_v_i = 1'b0;
        #1;
        total++;
        if (stall_v_o !== 1'b1) begin
            bad++; $display("FAIL stall_release: got %b want 1", stall_v_o);
        end
        tick();
        total++;
        if (cword_o !== model_cword(cw, word)) begin
            bad++; $display("FAIL stall_buffered: got %h want %h", cword_o, model_cword(cw, word));
        end
        cword_i = make_cw(OP_ALU, 3'd0, $urandom);
        #1;
        total++;
        if (stall_v_o !== 1'b0) begin
            bad++; $display("FAIL stall_done: got %b want 0", stall_v_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        cword_i = make_cw(OP_LOAD, 3'd2, aligned_addr(3'd2));
        dmem_req_ready_i = 1'b1;
        tick();
        dmem_req_ready_i = 1'b0;
        #1;
        total++;
        if (stall_v_o !== 1'b1) begin
            bad++; $display("FAIL rst_pre_wait: got stall=%b want 1", stall_v_o);
        end
        #1;
        rst_i = 1'b0;
        #1;
        total++;
        if ({cword_o, dmem_req_v_o, stall_v_o} !== '0) begin
            bad++; $display("FAIL rst_mid_wait: got cword=%h req=%b stall=%b want all 0", cword_o, dmem_req_v_o, stall_v_o);
        end
        tick();
        rst_i = 1'b1;
        run_load(make_cw(OP_LOAD, 3'd5, aligned_addr(3'd5)), 1, 1, $urandom, "after_reset");
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store();
        test_load_signed();
        test_backpressure();
        test_random_loads();
        test_flush_wait();
        test_misalign();
        test_stall_buffer();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
